// File: rtl/led_pattern_gen.sv
// led_pattern_gen: LED pattern generator for board bring-up.
// A power-of-two prescaler paces four patterns (binary, Gray, scanner, bar)
// with a pause control. Define LED_PATTERN_PWM_EN to add a global PWM
// brightness stage and the bright input.
module led_pattern_gen #(
  parameter int WIDTH     = 8,
  parameter int LOG2DELAY = 22,
  parameter int PWM_BITS  = 4
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [1:0]          mode,
  input  logic                pause,
`ifdef LED_PATTERN_PWM_EN
  input  logic [PWM_BITS-1:0] bright,
`endif
  output logic [WIDTH-1:0]    leds,
  output logic                tick
);

  localparam int PW = $clog2(WIDTH + 1);
  localparam logic [PW-1:0] SCAN_END = PW'(WIDTH - 1);
  localparam logic [PW-1:0] BAR_END  = PW'(WIDTH);

  typedef enum logic [1:0] {M_BIN, M_GRAY, M_SCAN, M_BAR} mode_e;

  logic [LOG2DELAY-1:0] pre;
  logic                 step;
  mode_e                mode_q, mode_n;
  logic [WIDTH-1:0]     cnt, cnt_n;
  logic [PW-1:0]        pos, pos_n;
  logic                 dir, dir_n;   // 0 = up, 1 = down
  logic [WIDTH-1:0]     pat, pat_n;
  logic [WIDTH-1:0]     onehot_n, bar_n;

  // A step fires when the prescaler is about to wrap and nothing holds it.
  assign step = !pause && (&pre);

  // Prescaler: frozen by pause, wraps naturally at all-ones.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)    pre <= '0;
    else if (!pause) pre <= pre + 1'b1;
  end

  // Next pattern state: a mode change reloads the start value, otherwise advance.
  always_comb begin
    mode_n = mode_q;
    cnt_n  = cnt;
    pos_n  = pos;
    dir_n  = dir;
    if (mode_e'(mode) != mode_q) begin
      mode_n = mode_e'(mode);
      cnt_n  = '0;
      pos_n  = '0;
      dir_n  = 1'b0;
    end else begin
      case (mode_q)
        M_BIN, M_GRAY: cnt_n = cnt + 1'b1;
        M_SCAN: begin
          if (!dir) begin
            if (pos == SCAN_END) begin dir_n = 1'b1; pos_n = pos - 1'b1; end
            else                         pos_n = pos + 1'b1;
          end else begin
            if (pos == '0) begin dir_n = 1'b0; pos_n = pos + 1'b1; end
            else                   pos_n = pos - 1'b1;
          end
        end
        default: begin
          if (!dir) begin
            if (pos == BAR_END) begin dir_n = 1'b1; pos_n = pos - 1'b1; end
            else                        pos_n = pos + 1'b1;
          end else begin
            if (pos == '0) begin dir_n = 1'b0; pos_n = pos + 1'b1; end
            else                   pos_n = pos - 1'b1;
          end
        end
      endcase
    end
  end

  // Per-LED decode of the next position into one-hot and thermometer forms.
  for (genvar i = 0; i < WIDTH; i++) begin : g_dec
    assign onehot_n[i] = (pos_n == PW'(i));
    assign bar_n[i]    = (PW'(i) < pos_n);
  end

  // Pattern select on the next mode so the register holds the final LED image.
  always_comb begin
    pat_n = '0;
    case (mode_n)
      M_BIN:   pat_n = cnt_n;
      M_GRAY:  pat_n = cnt_n ^ (cnt_n >> 1);
      M_SCAN:  pat_n = onehot_n;
      default: pat_n = bar_n;
    endcase
  end

  // Pattern state and registered outputs, updated only on steps.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mode_q <= M_BIN;
      cnt    <= '0;
      pos    <= '0;
      dir    <= 1'b0;
      pat    <= '0;
      tick   <= 1'b0;
    end else begin
      tick <= step;
      if (step) begin
        mode_q <= mode_n;
        cnt    <= cnt_n;
        pos    <= pos_n;
        dir    <= dir_n;
        pat    <= pat_n;
      end
    end
  end

`ifdef LED_PATTERN_PWM_EN
  logic [PWM_BITS-1:0] pwm;
  logic                pwm_on;

  // Free-running PWM ramp and registered duty-cycle enable; pause has no effect.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pwm    <= '0;
      pwm_on <= 1'b0;
    end else begin
      pwm    <= pwm + 1'b1;
      pwm_on <= (&bright) || (pwm < bright);
    end
  end

  assign leds = pat & {WIDTH{pwm_on}};
`else
  assign leds = pat;
`endif

endmodule
